// File: rtl/shift_issue_queue.sv
// Shift request queue and sequencer in front of the 32-bit left barrel shifter.
// Latency: 1 edge from acceptance to res_valid (2 edges for ROL with non-zero amount).
// Backpressure: res_ready low stalls capture; the FIFO fills to DEPTH and req_ready falls.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake; req_op/req_a/req_amt carry the request
//   sh_a, sh_movement               operand and bit-reversed amount driven to the external shifter
//   sh_out                          combinational shifter result
//   res_valid/res_ready             result handshake; res_data/res_zero/res_neg carry the result
//   op_count                        completed-op counter, present only with SHIFT_ISSUE_STATS_EN
//
// Optional feature macro: SHIFT_ISSUE_STATS_EN (adds op_count).
module shift_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [4:0]  req_amt,
    output logic [31:0] sh_a,
    output logic [4:0]  sh_movement,
    input  logic [31:0] sh_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_zero,
    output logic        res_neg
`ifdef SHIFT_ISSUE_STATS_EN
    ,
    output logic [15:0] op_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_ROL2  = 1'b1
    } state_t;

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    function automatic logic [4:0] rev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    // ---------------- request FIFO ----------------
    logic [1:0]  r_op_mem  [DEPTH];
    logic [31:0] r_a_mem   [DEPTH];
    logic [4:0]  r_amt_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_head_op;
    logic [31:0] w_head_a;
    logic [4:0]  w_head_amt;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = req_valid && !w_full;

    assign w_head_op  = r_op_mem[r_rd_ptr[AW-1:0]];
    assign w_head_a   = r_a_mem[r_rd_ptr[AW-1:0]];
    assign w_head_amt = r_amt_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr[AW-1:0]]  <= req_op;
            r_a_mem[r_wr_ptr[AW-1:0]]   <= req_a;
            r_amt_mem[r_wr_ptr[AW-1:0]] <= req_amt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // ---------------- sequencer ----------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_partial;
    logic [31:0] w_sh_a;
    logic [4:0]  w_amt;
    logic [31:0] w_result;
    logic        w_final;
    logic        w_rol_start;
    logic        w_capture;

    // Right shifts run through the left shifter on bit-reversed data; the
    // second ROL pass shifts rev(a) left by 32-amt, i.e. a >> (32-amt).
    always_comb begin
        w_sh_a      = '0;
        w_amt       = '0;
        w_result    = '0;
        w_final     = 1'b0;
        w_rol_start = 1'b0;
        if (!w_empty) begin
            case (w_head_op)
                OP_SLL: begin
                    w_sh_a   = w_head_a;
                    w_amt    = w_head_amt;
                    w_result = sh_out;
                    w_final  = 1'b1;
                end
                OP_SRL: begin
                    w_sh_a   = rev32(w_head_a);
                    w_amt    = w_head_amt;
                    w_result = rev32(sh_out);
                    w_final  = 1'b1;
                end
                OP_SRA: begin
                    w_sh_a   = rev32(w_head_a);
                    w_amt    = w_head_amt;
                    w_result = rev32(sh_out) |
                               (w_head_a[31] ? ~(32'hFFFF_FFFF >> w_head_amt) : 32'h0);
                    w_final  = 1'b1;
                end
                OP_ROL: begin
                    if (r_state == ST_ROL2) begin
                        w_sh_a   = rev32(w_head_a);
                        w_amt    = 5'd0 - w_head_amt;
                        w_result = r_partial | rev32(sh_out);
                        w_final  = 1'b1;
                    end else begin
                        w_sh_a = w_head_a;
                        w_amt  = w_head_amt;
                        if (w_head_amt == 5'd0) begin
                            w_result = w_head_a;
                            w_final  = 1'b1;
                        end else begin
                            w_rol_start = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign w_capture = w_final && (!res_valid || res_ready);
    assign w_pop     = w_capture;

    // The first ROL pass never waits on the output register; only capture does.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ISSUE: if (w_rol_start) w_state_nxt = ST_ROL2;
            ST_ROL2:  if (w_capture)   w_state_nxt = ST_ISSUE;
            default:  w_state_nxt = ST_ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ISSUE;
            r_partial <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rol_start) r_partial <= sh_out;
        end
    end

    // ---------------- output register ----------------
    logic        r_res_valid;
    logic [31:0] r_res_data;
    logic        r_res_zero;
    logic        r_res_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_zero  <= 1'b1;
            r_res_neg   <= 1'b0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_result;
            r_res_zero  <= (w_result == 32'h0);
            r_res_neg   <= w_result[31];
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef SHIFT_ISSUE_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_capture) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

    assign req_ready   = !w_full;
    assign sh_a        = w_sh_a;
    assign sh_movement = rev5(w_amt);
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_zero    = r_res_zero;
    assign res_neg     = r_res_neg;

endmodule

// File: doc/shift_issue_queue.md
# shift_issue_queue

Request queue and sequencer for the 32-bit left barrel shifter in the ALU datapath. It buffers shift requests, drives the shifter's combinational operand ports, and registers the returned result with flags. Right shifts (logical and arithmetic) are built from left shifts by bit-reversal. Rotates are built from two shifter passes. Results go out on a valid/ready port in request order.

## Interface
- DEPTH, 4, request FIFO entries (power of two, ≥2)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request offered
- req_ready  output  1  queue can accept (= !full)
- req_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
- req_a  input  32  operand
- req_amt  input  5  shift amount 0..31
- sh_a  output  32  shifter data operand
- sh_movement  output  5  shifter amount, bit-reversed encoding: bit4 = shift 1, bit3 = 2, bit2 = 4, bit1 = 8, bit0 = 16
- sh_out  input  32  shifter result (combinational from sh_a/sh_movement)
- res_valid  output  1  result held
- res_ready  input  1  consumer accepts
- res_data  output  32  result
- res_zero  output  1  res_data == 0
- res_neg  output  1  res_data[31]
- op_count  output  16  completed-op counter (only with SHIFT_ISSUE_STATS_EN)

## Operation
- FIFO: push on req_valid && req_ready. Pop when the head completes (see capture). No pass-through when full. A simultaneous push and pop when full is not possible, because req_ready is low.
- Head drives the shifter whenever the FIFO is non-empty. When empty: sh_a = 0, sh_movement = 0.
- sh_movement = bitreverse(amount) in all passes.
- SLL: sh_a = a; result = sh_out.
- SRL: sh_a = rev(a); result = rev(sh_out).
- SRA: as SRL, then if a[31], OR in mask ~(32'hFFFF_FFFF >> amt).
- ROL, amt = 0: single pass, result = a.
- ROL, amt ≠ 0:
  - Pass 1 (state ISSUE): SLL by amt. Store sh_out in internal partial register. Go to ROL2. No pop.
  - Pass 2 (state ROL2): sh_a = rev(a), amount = (32 − amt) & 31. Result = partial | rev(sh_out).
- FSM states: ISSUE (reset) and ROL2.
  - ISSUE → ROL2 only for a head ROL with amt ≠ 0 and FIFO non-empty. This move does not wait on the output register.
  - ROL2 → ISSUE on capture.
- Capture: when the head result is final and (!res_valid || res_ready), load res_data, res_zero and res_neg, set res_valid, and pop the head.
- Output: res_valid clears on res_valid && res_ready with no new capture. Capture and drain in the same cycle is allowed, giving a full-throughput stream.
- Results leave in request order. Arithmetic is 32-bit unsigned except the SRA sign fill.

## Timing
- Reset values: req_ready = 1, res_valid = 0, res_data = 0, res_zero = 1, res_neg = 0, sh_a = 0, sh_movement = 0, op_count = 0, FSM = ISSUE, FIFO empty, partial = 0.
- Reset is asynchronous at any time, including in ROL2: the in-flight result and all queued entries are discarded.
- Latency, non-ROL and ROL amt = 0: accepted at edge E0, res_valid high after E1 if the output register is free.
- Latency, ROL amt ≠ 0: two edges (E1 pass 1, E2 capture).
- Throughput: one non-ROL op per cycle; ROL amt ≠ 0 takes two cycles.
- Combinational path within one cycle: FIFO head → sh_a/sh_movement → shifter → sh_out → result mux → res_data D-input.
- Back-pressure: res_ready low stalls capture. The FIFO fills to DEPTH, then req_ready falls in the cycle after the DEPTH-th push. Total buffering is DEPTH + 1 results (FIFO plus output register).
- FIFO pointers: log2(DEPTH) + 1 bits, wrap naturally.

## Configuration
- SHIFT_ISSUE_STATS_EN defined:
  - op_count port exists.
  - It increments by 1 on each capture and wraps at 0xFFFF → 0.
  - It is cleared by rst_n.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- SLL a = 0x0000_0001, amt = 5 → sh_movement = 5'b10100; res_data = 0x0000_0020, res_zero = 0, res_valid one edge after acceptance.
- SRL a = 0x8000_0000, amt = 4 → 0x0800_0000, res_neg = 0.
- SRA, same operands → 0xF800_0000, res_neg = 1.
- SRL a = 0x0000_000F, amt = 31 → 0x0000_0000, res_zero = 1.
- ROL a = 0x8000_0001, amt = 1 → 0x0000_0003, two edges after acceptance.
- ROL amt = 0 → 0x8000_0001 after one edge.
- Back-to-back ROL/SLL: results stay in order.
- DEPTH = 4, res_ready = 0, stream 7 SLL requests → exactly 5 accepted, req_ready low. Then res_ready = 1 → 5 results in order, one per cycle, then the remaining 2 requests are accepted.
- Assert rst_n = 0 during ROL2 with 3 entries queued → immediately res_valid = 0, sh_a = 0. After release: req_ready = 1, no stale result appears.
- With SHIFT_ISSUE_STATS_EN: 3 ops (including one ROL) → op_count = 3. Preload 0xFFFF, one more op → 0x0000.
